// File: rtl/result_uart_tx.sv
// Sends {result, flags} as a 7-byte ASCII line "HHHHF\r\n" over an 8N1 UART.
// Bytes go back-to-back; the next byte comes straight from the captured value.
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] result,
  input  logic [3:0]  flags,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic [15:0]   result_q, result_d;
  logic [3:0]    flags_q, flags_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    cur_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) c = 8'h30 + {4'h0, n};
    else           c = 8'h37 + {4'h0, n};
    return c;
  endfunction

  function automatic logic [7:0] line_byte(input logic [2:0] idx,
                                           input logic [15:0] r,
                                           input logic [3:0] f);
    logic [7:0] b;
    case (idx)
      3'd0:    b = hex_ascii(r[15:12]);
      3'd1:    b = hex_ascii(r[11:8]);
      3'd2:    b = hex_ascii(r[7:4]);
      3'd3:    b = hex_ascii(r[3:0]);
      3'd4:    b = hex_ascii(f);
      3'd5:    b = 8'h0D;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    cur_byte = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_START;
          baud_d   = '0;
          bit_d    = 3'd0;
          byte_d   = 3'd0;
          result_d = result;
          flags_d  = flags;
        end
      end
      S_START, S_DATA, S_STOP: begin
        if (baud_q != BAUD_LAST) begin
          baud_d = baud_q + 1'b1;
        end else begin
          // Bit boundary: the baud counter restarts so periods never drift.
          baud_d = '0;
          if (state_q == S_START) begin
            state_d = S_DATA;
            bit_d   = 3'd0;
          end else if (state_q == S_DATA) begin
            if (bit_q == 3'd7) state_d = S_STOP;
            else               bit_d   = bit_q + 3'd1;
          end else if (byte_q < 3'd6) begin
            byte_d  = byte_q + 3'd1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The serial line is registered from the next state so it moves with busy.
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA: begin
        cur_byte = line_byte(byte_d, result_d, flags_d);
        tx_d     = cur_byte[bit_d];
      end
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      byte_q   <= 3'd0;
      result_q <= 16'h0000;
      flags_q  <= 4'h0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx at 4 clocks per bit: decodes each line
// sampled on the falling edge and checks bytes, framing, busy and done timing.
module tb_result_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] result;
  logic [3:0]  flags;
  logic        tx;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [55:0] rx_word;
  logic        rx_first_data;
  int          rx_frame_err;
  int          rx_unstable;
  int          rx_busy_cnt;
  int          rx_done_cnt;
  logic        rx_end_done, rx_end_busy, rx_end_tx;
  int          idle_bad;

  result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .result    (result),
    .flags     (flags),
    .tx        (tx),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: start is raised before an edge and dropped just after it.
  task automatic pulse_start(input logic [15:0] r, input logic [3:0] f);
    @(negedge clk);
    start  = 1'b1;
    result = r;
    flags  = f;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Receiver: called right after the accepting edge; samples 70 bit periods,
  // then the following cycle where done is expected.
  task automatic rx_line(input int poke_at);
    logic [7:0] b;
    logic       bitv;
    int         idx;
    rx_word = '0; rx_frame_err = 0; rx_unstable = 0;
    rx_busy_cnt = 0; rx_done_cnt = 0; rx_first_data = 1'bx;
    for (int j = 0; j < 7; j++) begin
      b = 8'h00;
      for (int k = 0; k < 10; k++) begin
        bitv = 1'bx;
        for (int c = 0; c < CPB; c++) begin
          idx = (j * 10 + k) * CPB + c;
          @(negedge clk);
          if (c == 0) bitv = tx;
          else if (tx !== bitv) rx_unstable++;
          if (busy === 1'b1) rx_busy_cnt++;
          if (done !== 1'b0) rx_done_cnt++;
          if (poke_at >= 0 && idx == poke_at) begin
            start = 1'b1; result = 16'h1234; flags = 4'hF;
          end else if (poke_at >= 0 && idx == poke_at + 1) begin
            start = 1'b0;
          end
        end
        if (k == 0 && bitv !== 1'b0) rx_frame_err++;
        if (k == 9 && bitv !== 1'b1) rx_frame_err++;
        if (k >= 1 && k <= 8) b[k-1] = bitv;
        if (j == 0 && k == 1) rx_first_data = bitv;
      end
      rx_word = {rx_word[47:0], b};
    end
    @(negedge clk);
    rx_end_done = done;
    rx_end_busy = busy;
    rx_end_tx   = tx;
  endtask

  task automatic idle_watch(input int n);
    idle_bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_bad++;
    end
  endtask

  task automatic check_line(input string tag, input logic [55:0] exp_word);
    chk({tag, "_bytes"}, 64'(rx_word), 64'(exp_word));
    chk({tag, "_framing"}, 64'(rx_frame_err), 64'd0);
    chk({tag, "_bit_period"}, 64'(rx_unstable), 64'd0);
    chk({tag, "_busy_cycles"}, 64'(rx_busy_cnt), 64'(70 * CPB));
    chk({tag, "_done_early"}, 64'(rx_done_cnt), 64'd0);
    chk({tag, "_done_end"}, 64'({rx_end_done, rx_end_busy, rx_end_tx}), 64'b101);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; result = 16'h0000; flags = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({tx, busy, done}), 64'b100);
    rst = 1'b0;

    idle_watch(1000);
    chk("idle_after_reset", 64'(idle_bad), 64'd0);

    pulse_start(16'h3C00, 4'h0);
    rx_line(-1);
    check_line("line_3c00", 56'h33433030300D0A);

    pulse_start(16'hFA9B, 4'hA);
    rx_line(-1);
    check_line("line_fa9b", 56'h46413942410D0A);
    chk("fa9b_first_data_bit", 64'(rx_first_data), 64'd0);

    pulse_start(16'h0F0F, 4'h3);
    rx_line(50);
    check_line("line_busy_start", 56'h30463046330D0A);
    idle_watch(300);
    chk("no_second_line", 64'(idle_bad), 64'd0);

    @(negedge clk);
    start = 1'b1; result = 16'h0001; flags = 4'h0;
    @(posedge clk);
    rx_line(-1);
    check_line("hold_line1", 56'h30303031300D0A);
    rx_line(-1);
    start = 1'b0;
    check_line("hold_line2", 56'h30303031300D0A);
    idle_watch(20);
    chk("hold_released_idle", 64'(idle_bad), 64'd0);

    pulse_start(16'hABCD, 4'h1);
    repeat (130) @(negedge clk);
    chk("busy_before_reset", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", 64'({tx, busy, done}), 64'b100);
    @(negedge clk);
    rst = 1'b0;
    idle_watch(10);
    chk("idle_after_midframe_reset", 64'(idle_bad), 64'd0);

    pulse_start(16'h5E7F, 4'h5);
    rx_line(-1);
    check_line("line_after_reset", 56'h35453746350D0A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Serial output path for the fixed/floating adder-multiplier test top.
- Takes the 16-bit arithmetic result and 4 status flags in parallel.
- Transmits them as an ASCII line over an 8N1 UART, so results can be captured on a host in addition to the seven-segment display.
- Sits beside the SSD controller and is driven by the top's result mux and a one-cycle start pulse.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200 baud); must be >= 2.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request to send a line; sampled every cycle
- result  input  16  value to print; captured on the accepting cycle
- flags  input  4  {overflow, zero, NaN, precisionLost}; captured on the accepting cycle
- tx  output  1  UART serial line, idle high
- busy  output  1  high while a line is being transmitted
- done  output  1  one-cycle pulse when the last stop bit of a line completes

Behaviour:
- Reset values (async, immediate, including mid-frame):
  - tx=1, busy=0, done=0
  - state=IDLE; all counters and shift registers zero
  - a partial frame is abandoned, not resumed
- Line format: 7 bytes, sent in this order:
  - hex digits of result[15:12], [11:8], [7:4], [3:0]
  - hex digit of flags[3:0]
  - 0x0D (CR), then 0x0A (LF)
- Hex encoding, uppercase: 0-9 -> 0x30-0x39; A-F -> 0x41-0x46.
- Byte framing: start bit 0, data bits b0..b7 (LSB first), stop bit 1.
  - Every bit is held exactly CLKS_PER_BIT cycles.
  - Bytes go back-to-back, with no idle gap between a stop bit and the next start bit.
- FSM states:
  - IDLE: tx=1, busy=0. start=1 captures result/flags, clears byte index, and moves to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx = current data bit; bit index 0..7; after bit 7's period, move to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte index < 6, increment it, load the next byte, and go to START. Otherwise go to IDLE and assert done for that one cycle.
- Latency:
  - start sampled high at edge N -> tx=0 and busy=1 from edge N.
  - Full line takes 70*CLKS_PER_BIT cycles from the accepting edge to the edge where done rises.
- busy is registered: high from the accepting edge until the edge returning to IDLE.
- done is registered: high exactly one cycle, coincident with the first IDLE cycle (busy=0).
- start while busy: ignored, no queueing; result/flags changes mid-line do not affect output.
- start high during the done cycle: accepted; the next line begins with no extra idle beyond that cycle.
- start held high continuously: lines repeat, each separated by exactly one idle (tx=1) cycle.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; it is reset on each bit transition, with no accumulated drift.

Test Plan:
- CLKS_PER_BIT=4; result=0x3C00, flags=0x0, pulse start.
  - Decoded bytes: 0x33 0x43 0x30 0x30 0x30 0x0D 0x0A.
  - done rises 280 cycles after the accepting edge.
  - busy is high for exactly 280 cycles.
- result=0xFA9B, flags=0xA.
  - Bytes: 0x46 0x41 0x39 0x42 0x41 0x0D 0x0A.
  - Bit periods are exactly 4 cycles each; the first transmitted data bit of 0x46 is 0.
- Pulse start at cycle 50 of a line, with result changed.
  - The first line completes unaltered.
  - No second line follows; tx stays 1 after done.
- Hold start high for 600 cycles with result=0x0001.
  - Two full lines, separated by exactly one tx=1 idle cycle.
  - done pulses twice, each for 1 cycle.
- Assert rst during DATA of byte 3.
  - tx=1, busy=0, done=0 immediately.
  - After release, a new start transmits a complete fresh 7-byte line.
- Reset with no start for 1000 cycles: tx stays 1, busy stays 0, done stays 0 throughout.
